fetch_tr: RTL and testbench

//  Instruction fetch/issue front end: producer side of the 32-bit TR bus consumed by the datapath.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_tr_if.sv | 11 +
 rtl/fifo_tr.sv | 47 ++++
 rtl/fetch_tr.sv | 102 ++++++++++
 tb/tb_fetch_tr.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared opcodes and FSM encoding for the fetch/issue front end.
package fetch_pkg;

  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT_ZF = 2'd1,
    HALT    = 2'd2
  } state_t;

  function automatic logic [5:0] opcode(input logic [31:0] w);
    return w[31:26];
  endfunction

endpackage

// File: rtl/fetch_tr_if.sv
// TR bus between fetch (master) and datapath (slave), including ZF feedback.
interface fetch_tr_if;
  logic [31:0] tr;
  logic        tr_valid;
  logic        tr_ready;
  logic        tr_zf;
  logic        zf_valid;

  modport master (output tr, tr_valid, input tr_ready, tr_zf, zf_valid);
  modport slave  (input tr, tr_valid, output tr_ready, tr_zf, zf_valid);
endinterface

// File: rtl/fifo_tr.sv
// Synchronous prefetch FIFO; flush has priority over push.
module fifo_tr #(
  parameter int W     = 40,
  parameter int DEPTH = 4
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW:0]             wp, rp;
  logic                    do_push, do_pop;

  // Extra pointer bit distinguishes full from empty.
  always_comb begin
    count   = wp - rp;
    empty   = (wp == rp);
    full    = (count == (AW+1)'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dout    = mem[rp[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (do_pop)  rp <= rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fetch_tr.sv
// Instruction fetch/issue front end: prefetches into a FIFO, issues on TR, resolves BEQ via ZF.
module fetch_tr
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
)(
  input  logic              clk,
  input  logic              rst,
  output logic              im_rd,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [31:0]       im_data,
  fetch_tr_if.master        bus,
  output logic              halted
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = 32 + ADDR_W;

  state_t            state;
  logic [ADDR_W-1:0] pc, ret_pc, br_pc, target, head_pc;
  logic [15:0]       br_imm;
  logic [31:0]       imm_sx, head_instr;
  logic [EW-1:0]     head;
  logic              inflight, push, pop, flush, full, empty, room, is_beq, is_halt;
  logic [CW-1:0]     count, cnt_nx;
  logic [CW:0]       credit;

  fifo_tr #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ({im_data, ret_pc}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    head_instr   = head[EW-1:ADDR_W];
    head_pc      = head[ADDR_W-1:0];
    bus.tr_valid = !empty && (state == RUN);
    bus.tr       = empty ? '0 : head_instr;
    pop          = bus.tr_valid && bus.tr_ready;
    is_beq       = (opcode(head_instr) == OP_BEQ);
    is_halt      = (opcode(head_instr) == OP_HALT);
    flush        = (state == WAIT_ZF) && bus.zf_valid && bus.tr_zf;
    push         = inflight && !flush;
    // im_rd is registered, so a read being issued now also holds a FIFO slot.
    cnt_nx       = flush ? '0 : count + CW'(push) - CW'(pop);
    credit       = {1'b0, cnt_nx} + (CW+1)'(im_rd);
    room         = (credit < (CW+1)'(FIFO_DEPTH)) && !(full && !pop);
    imm_sx       = {{16{br_imm[15]}}, br_imm};
    target       = br_pc + imm_sx[ADDR_W-1:0] + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      pc       <= RESET_PC;
      im_rd    <= 1'b0;
      im_addr  <= RESET_PC;
      inflight <= 1'b0;
      ret_pc   <= RESET_PC;
      br_pc    <= '0;
      br_imm   <= '0;
      halted   <= 1'b0;
    end else begin
      inflight <= im_rd && !flush;
      ret_pc   <= im_addr;
      im_rd    <= 1'b0;
      if (flush) begin
        pc    <= target;
        state <= RUN;
      end else begin
        case (state)
          RUN: begin
            if (pop && is_beq) begin
              state  <= WAIT_ZF;
              br_pc  <= head_pc;
              br_imm <= head_instr[15:0];
            end else if (pop && is_halt) begin
              state  <= HALT;
              halted <= 1'b1;
            end
          end
          WAIT_ZF: if (bus.zf_valid) state <= RUN;
          default: ;
        endcase
        if (state != HALT && !(pop && is_halt) && room) begin
          im_rd   <= 1'b1;
          im_addr <= pc;
          pc      <= pc + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_tr.sv
// Directed bench for fetch_tr: cycle table for straight-line fetch plus branch/halt/reset sequences.
module tb_fetch_tr;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        im_rd;
  logic [7:0]  im_addr;
  logic [31:0] im_data;
  logic        halted;
  logic [31:0] mem [256];
  logic [31:0] issued [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  fetch_tr_if bus();

  fetch_tr #(.ADDR_W(8), .FIFO_DEPTH(4), .RESET_PC(8'd0)) dut (
    .clk     (clk),
    .rst     (rst),
    .im_rd   (im_rd),
    .im_addr (im_addr),
    .im_data (im_data),
    .bus     (bus.master),
    .halted  (halted)
  );

  always #5 clk = ~clk;

  // 1-cycle latency instruction memory
  always @(posedge clk) if (im_rd) im_data <= mem[im_addr];

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        e_rd;
    logic [7:0]  e_addr;
    logic        e_tv;
    logic [31:0] e_tr;
    logic        e_h;
  } vec_t;
  vec_t tbl [9];

  function automatic logic [31:0] w(input int i);
    return 32'h0000_0100 + 32'(i);
  endfunction

  function automatic logic [31:0] beq(input logic [15:0] imm);
    return {6'b000100, 10'd0, imm};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    if (bus.tr_valid && bus.tr_ready) issued.push_back(bus.tr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_mem();
    for (int j = 0; j < 256; j++) mem[j] = w(j);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.tr_ready = 1'b0;
    bus.zf_valid = 1'b0;
    bus.tr_zf = 1'b0;
    cyc();
    cyc();
    issued.delete();
    rst = 1'b0;
  endtask

  task automatic collect(input int n, input string nm);
    int b = 0;
    while (issued.size() < n && b < 40) begin
      cyc();
      b++;
    end
    if (issued.size() < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout, got %0d words, expected %0d", nm, issued.size(), n);
    end
  endtask

  task automatic wait_issue(input logic [31:0] wd, input string nm);
    int b = 0;
    while (!(issued.size() > 0 && issued[issued.size()-1] == wd) && b < 40) begin
      cyc();
      b++;
    end
    chk({nm, "_seen"}, 32'(issued.size() > 0 && issued[issued.size()-1] == wd), 32'd1);
  endtask

  // Called right after the BEQ transfer edge.
  task automatic take_branch(input logic zf, input logic [7:0] exp_addr,
                             input logic [31:0] exp_next, input string nm);
    int n;
    chk({nm, "_hold"}, 32'(bus.tr_valid), 32'd0);
    cyc();
    bus.zf_valid = 1'b1;
    bus.tr_zf = zf;
    cyc();
    bus.zf_valid = 1'b0;
    bus.tr_zf = 1'b0;
    if (zf) begin
      chk({nm, "_rd_off"}, 32'(im_rd), 32'd0);
      chk({nm, "_empty"}, 32'(bus.tr_valid), 32'd0);
      cyc();
      chk({nm, "_addr"}, {23'd0, im_rd, im_addr}, {23'd0, 1'b1, exp_addr});
    end
    n = issued.size();
    collect(n + 1, nm);
    if (issued.size() > n) chk({nm, "_next"}, issued[n], exp_next);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, bad;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 32'h0,   1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 32'h0,   1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 32'h0,   1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 8'd2, 1'b1, 32'h100, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 8'd3, 1'b1, 32'h101, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 8'd4, 1'b1, 32'h102, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 8'd5, 1'b1, 32'h103, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 8'd6, 1'b1, 32'h104, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 8'd7, 1'b1, 32'h105, 1'b0};

    bus.tr_ready = 1'b0;
    bus.zf_valid = 1'b0;
    bus.tr_zf = 1'b0;
    load_mem();
    @(negedge clk);
    cyc();

    // straight-line fetch, row i = outputs after edge i
    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst;
      bus.tr_ready = tbl[i].rdy;
      cyc();
      chk($sformatf("sl%0d_im_rd", i), 32'(im_rd), 32'(tbl[i].e_rd));
      chk($sformatf("sl%0d_im_addr", i), 32'(im_addr), 32'(tbl[i].e_addr));
      chk($sformatf("sl%0d_tr_valid", i), 32'(bus.tr_valid), 32'(tbl[i].e_tv));
      chk($sformatf("sl%0d_tr", i), bus.tr, tbl[i].e_tr);
      chk($sformatf("sl%0d_halted", i), 32'(halted), 32'(tbl[i].e_h));
    end

    // backpressure
    load_mem();
    do_reset();
    p = 0;
    repeat (10) begin
      cyc();
      if (im_rd) p++;
    end
    chk("bp_rd_pulses", 32'(p), 32'd4);
    chk("bp_tr_valid", 32'(bus.tr_valid), 32'd1);
    chk("bp_head", bus.tr, w(0));
    bus.tr_ready = 1'b1;
    collect(8, "bp_collect");
    for (int k = 0; k < 8; k++)
      if (issued.size() > k) chk($sformatf("bp_word%0d", k), issued[k], w(k));

    // BEQ not taken
    load_mem();
    mem[2] = beq(16'd5);
    do_reset();
    bus.tr_ready = 1'b1;
    wait_issue(beq(16'd5), "nt_beq");
    take_branch(1'b0, 8'd0, w(3), "nt");
    collect(5, "nt_more");
    if (issued.size() > 4) chk("nt_word4", issued[4], w(4));

    // BEQ taken, then target wrap through 254
    load_mem();
    mem[2] = beq(16'd5);
    do_reset();
    bus.tr_ready = 1'b1;
    wait_issue(beq(16'd5), "tk_beq");
    take_branch(1'b1, 8'd8, w(8), "tk");

    load_mem();
    mem[2] = beq(16'hFFFB);
    mem[254] = beq(16'd3);
    do_reset();
    bus.tr_ready = 1'b1;
    wait_issue(beq(16'hFFFB), "wrap_beq");
    take_branch(1'b1, 8'd254, beq(16'd3), "back");
    take_branch(1'b1, 8'd2, beq(16'hFFFB), "wrap");

    // HALT
    load_mem();
    mem[1] = HALT_W;
    do_reset();
    bus.tr_ready = 1'b1;
    wait_issue(HALT_W, "halt");
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_im_rd", 32'(im_rd), 32'd0);
    chk("halt_tr_valid", 32'(bus.tr_valid), 32'd0);
    bad = 0;
    repeat (12) begin
      bus.zf_valid = ~bus.zf_valid;
      bus.tr_zf = 1'b1;
      cyc();
      if (!(halted === 1'b1 && im_rd === 1'b0 && bus.tr_valid === 1'b0)) bad++;
    end
    bus.zf_valid = 1'b0;
    bus.tr_zf = 1'b0;
    chk("halt_stays", 32'(bad), 32'd0);
    chk("halt_issued", 32'(issued.size()), 32'd2);

    // reset mid-fetch
    load_mem();
    do_reset();
    bus.tr_ready = 1'b1;
    cyc();
    chk("rm_first_rd", {23'd0, im_rd, im_addr}, {23'd0, 1'b1, 8'd0});
    rst = 1'b1;
    cyc();
    chk("rm_im_rd", 32'(im_rd), 32'd0);
    chk("rm_im_addr", 32'(im_addr), 32'd0);
    chk("rm_tr_valid", 32'(bus.tr_valid), 32'd0);
    chk("rm_tr", bus.tr, 32'd0);
    chk("rm_halted", 32'(halted), 32'd0);
    rst = 1'b0;
    issued.delete();
    cyc();
    chk("rm_refetch", {23'd0, im_rd, im_addr}, {23'd0, 1'b1, 8'd0});
    collect(3, "rm_collect");
    for (int k = 0; k < 3; k++)
      if (issued.size() > k) chk($sformatf("rm_word%0d", k), issued[k], w(k));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
